// File: rtl/addsub_pkg.sv
// Shared encodings for the add/sub accumulator sequencer: command ops, FSM states
// and the bit positions of the result flag vector.
package addsub_pkg;

  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_SUB   = 2'b01;
  localparam logic [1:0] OP_LOAD  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_SETTLE = 2'b01;
  localparam logic [1:0] ST_HOLD   = 2'b10;

  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 3;
  localparam int FLAG_W = 4;

  typedef logic [FLAG_W-1:0] flags_t;

  function automatic logic is_arith(input logic [1:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/addsub_acc_ctrl_if.sv
// Bus bundle for the accumulator sequencer: command handshake, result handshake
// and the side-channel to the external ripple-carry adder.
interface addsub_acc_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;

  logic [WIDTH-1:0] add_x;
  logic [WIDTH-1:0] add_y;
  logic             add_cin;
  logic [WIDTH-1:0] add_sum;
  logic             add_cout;

  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;
  logic             res_c;
  logic             res_z;
  logic             res_n;
  logic             res_v;

  // slave is the sequencer itself; master is the environment (commander, adder, sink)
  modport slave (
    input  cmd_valid, cmd_op, cmd_data, add_sum, add_cout, res_ready,
    output cmd_ready, add_x, add_y, add_cin,
           res_valid, res_data, res_c, res_z, res_n, res_v
  );

  modport master (
    output cmd_valid, cmd_op, cmd_data, add_sum, add_cout, res_ready,
    input  cmd_ready, add_x, add_y, add_cin,
           res_valid, res_data, res_c, res_z, res_n, res_v
  );

endinterface

// File: rtl/addsub_flag_gen.sv
// Combinational result select and C/Z/N/V flag generation for one completed command.
module addsub_flag_gen
  import addsub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] sum_i,
  input  logic             cout_i,
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] yeff_i,
  output logic [WIDTH-1:0] res_o,
  output flags_t           flags_o
);

  always_comb begin
    res_o   = '0;
    flags_o = '0;
    if (is_arith(op_i)) begin
      res_o           = sum_i;
      flags_o[FLAG_C] = cout_i;
      flags_o[FLAG_V] = (x_i[WIDTH-1] == yeff_i[WIDTH-1]) &&
                        (sum_i[WIDTH-1] != x_i[WIDTH-1]);
    end else if (op_i == OP_LOAD) begin
      // Cin is 0 for LOAD, so the effective Y is the latched operand unchanged
      res_o = yeff_i;
    end
    flags_o[FLAG_Z] = (res_o == '0);
    flags_o[FLAG_N] = res_o[WIDTH-1];
  end

endmodule

// File: rtl/addsub_acc_ctrl.sv
// Command sequencer around an external combinational adder/subtractor: holds the
// adder inputs for SETTLE_CYCLES, captures SUM into the accumulator, presents flags.
//   state     | meaning
//   ST_IDLE   | ready for a command
//   ST_SETTLE | adder inputs held, settle counter running down
//   ST_HOLD   | result presented until res_ready
module addsub_acc_ctrl
  import addsub_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rst,
  addsub_acc_ctrl_if.slave    bus,
  output logic [7:0]          op_count_o
);

  localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] op_reg_q, op_reg_d;
  logic             sub_q, sub_d;
  logic [1:0]       op_q, op_d;
  logic [3:0]       cnt_q, cnt_d;
  flags_t           flags_q, flags_d;
  logic [7:0]       op_count_q, op_count_d;

  logic [WIDTH-1:0] yeff;
  logic [WIDTH-1:0] res_w;
  flags_t           flags_w;

  assign yeff = op_reg_q ^ {WIDTH{sub_q}};

  addsub_flag_gen #(
    .WIDTH (WIDTH)
  ) u_flag_gen (
    .op_i    (op_q),
    .sum_i   (bus.add_sum),
    .cout_i  (bus.add_cout),
    .x_i     (acc_q),
    .yeff_i  (yeff),
    .res_o   (res_w),
    .flags_o (flags_w)
  );

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    op_reg_d   = op_reg_q;
    sub_d      = sub_q;
    op_d       = op_q;
    cnt_d      = cnt_q;
    flags_d    = flags_q;
    op_count_d = op_count_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          op_reg_d = bus.cmd_data;
          sub_d    = (bus.cmd_op == OP_SUB);
          op_d     = bus.cmd_op;
          cnt_d    = CNT_LOAD;
          state_d  = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        // add_sum is only trusted on the final settle edge
        if (cnt_q == 4'd0) begin
          acc_d   = res_w;
          flags_d = flags_w;
          state_d = ST_HOLD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_HOLD: begin
        if (bus.res_ready) begin
          op_count_d = op_count_q + 8'd1;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      acc_q      <= '0;
      op_reg_q   <= '0;
      sub_q      <= 1'b0;
      op_q       <= OP_ADD;
      cnt_q      <= '0;
      flags_q    <= '0;
      op_count_q <= '0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      op_reg_q   <= op_reg_d;
      sub_q      <= sub_d;
      op_q       <= op_d;
      cnt_q      <= cnt_d;
      flags_q    <= flags_d;
      op_count_q <= op_count_d;
    end
  end

  assign bus.cmd_ready = (state_q == ST_IDLE);
  assign bus.res_valid = (state_q == ST_HOLD);
  assign bus.add_x     = acc_q;
  assign bus.add_y     = op_reg_q;
  assign bus.add_cin   = sub_q;
  assign bus.res_data  = acc_q;
  assign bus.res_c     = flags_q[FLAG_C];
  assign bus.res_z     = flags_q[FLAG_Z];
  assign bus.res_n     = flags_q[FLAG_N];
  assign bus.res_v     = flags_q[FLAG_V];
  assign op_count_o    = op_count_q;

endmodule

// File: tb/tb_addsub_acc_ctrl.sv
// Random and directed checks of the accumulator sequencer at SETTLE_CYCLES=1 and 4,
// with a behavioural adder beside each DUT and an arithmetic reference model.
module tb_addsub_acc_ctrl;
  import addsub_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       sel;
  logic       cmd_valid;
  logic [1:0] cmd_op;
  logic [7:0] cmd_data;
  logic       res_ready;
  logic       corrupt;

  logic [7:0] opc1, opc4;
  logic [8:0] s1, s4;

  int         n_chk = 0;
  int         n_err = 0;
  logic [7:0] acc_m;
  int         cnt_m;

  always #5 clk = ~clk;

  addsub_acc_ctrl_if #(.WIDTH(8)) if1 ();
  addsub_acc_ctrl_if #(.WIDTH(8)) if4 ();

  assign if1.cmd_valid = cmd_valid & ~sel;
  assign if4.cmd_valid = cmd_valid & sel;
  assign if1.cmd_op    = cmd_op;
  assign if4.cmd_op    = cmd_op;
  assign if1.cmd_data  = cmd_data;
  assign if4.cmd_data  = cmd_data;
  assign if1.res_ready = res_ready & ~sel;
  assign if4.res_ready = res_ready & sel;

  assign s1 = {1'b0, if1.add_x} + {1'b0, if1.add_y ^ {8{if1.add_cin}}} + 9'(if1.add_cin);
  assign s4 = {1'b0, if4.add_x} + {1'b0, if4.add_y ^ {8{if4.add_cin}}} + 9'(if4.add_cin);
  assign if1.add_sum  = s1[7:0];
  assign if1.add_cout = s1[8];
  assign if4.add_sum  = corrupt ? ~s4[7:0] : s4[7:0];
  assign if4.add_cout = corrupt ? ~s4[8] : s4[8];

  addsub_acc_ctrl #(.WIDTH(8), .SETTLE_CYCLES(1)) u_dut1 (
    .clk        (clk),
    .rst        (rst),
    .bus        (if1.slave),
    .op_count_o (opc1)
  );

  addsub_acc_ctrl #(.WIDTH(8), .SETTLE_CYCLES(4)) u_dut4 (
    .clk        (clk),
    .rst        (rst),
    .bus        (if4.slave),
    .op_count_o (opc4)
  );

  logic       o_cmd_ready, o_res_valid, o_add_cin;
  logic [7:0] o_res_data, o_add_x, o_add_y, o_opc;
  logic [3:0] o_flags;

  assign o_cmd_ready = sel ? if4.cmd_ready : if1.cmd_ready;
  assign o_res_valid = sel ? if4.res_valid : if1.res_valid;
  assign o_add_cin   = sel ? if4.add_cin   : if1.add_cin;
  assign o_res_data  = sel ? if4.res_data  : if1.res_data;
  assign o_add_x     = sel ? if4.add_x     : if1.add_x;
  assign o_add_y     = sel ? if4.add_y     : if1.add_y;
  assign o_opc       = sel ? opc4          : opc1;
  assign o_flags     = sel ? {if4.res_v, if4.res_n, if4.res_z, if4.res_c}
                           : {if1.res_v, if1.res_n, if1.res_z, if1.res_c};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got 0x%0h exp 0x%0h (t=%0t sel=%0d)", tag, obs, exp, $time, sel);
    end
  endtask

  // Expected result from plain unsigned/signed arithmetic on the model accumulator
  task automatic model(input logic [1:0] op, input logic [7:0] d,
                       output logic [7:0] r, output bit c, output bit z,
                       output bit n, output bit v);
    int ua, ud, sa, sd, s;
    ua = acc_m;
    ud = d;
    sa = (ua > 127) ? ua - 256 : ua;
    sd = (ud > 127) ? ud - 256 : ud;
    c = 0;
    v = 0;
    r = 8'h00;
    case (op)
      OP_ADD: begin
        r = 8'((ua + ud) % 256);
        c = (ua + ud) > 255;
        s = sa + sd;
        v = (s > 127) || (s < -128);
      end
      OP_SUB: begin
        r = 8'((ua - ud + 256) % 256);
        c = ua >= ud;
        s = sa - sd;
        v = (s > 127) || (s < -128);
      end
      OP_LOAD: r = d;
      default: r = 8'h00;
    endcase
    z = (r == 8'h00);
    n = r[7];
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    acc_m = 8'h00;
    cnt_m = 0;
    chk("rst_cmd_ready", o_cmd_ready, 1);
    chk("rst_res_valid", o_res_valid, 0);
    chk("rst_op_count", o_opc, 0);
    chk("rst_res_data", o_res_data, 0);
    chk("rst_add_x", o_add_x, 0);
    chk("rst_flags", o_flags, 0);
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [7:0] d,
                         input int hold, input bit glitch);
    logic [7:0] er;
    bit ec, ez, en, ev;
    int lat, ns;
    ns = sel ? 4 : 1;
    model(op, d, er, ec, ez, en, ev);
    cmd_op    = op;
    cmd_data  = d;
    cmd_valid = 1'b1;
    lat = 0;
    while (!o_cmd_ready && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("accept_ready", o_cmd_ready, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_data  = 8'($urandom);
    cmd_op    = 2'($urandom);
    chk("settle_cmd_ready", o_cmd_ready, 0);
    chk("settle_add_x", o_add_x, acc_m);
    chk("settle_add_y", o_add_y, d);
    chk("settle_add_cin", o_add_cin, (op == OP_SUB));
    lat = 1;
    while (!o_res_valid && lat < 40) begin
      corrupt = glitch && (lat < ns);
      @(posedge clk); #1;
      lat++;
    end
    corrupt = 1'b0;
    chk("latency", lat, ns + 1);
    for (int i = 0; i <= hold; i++) begin
      chk("hold_res_valid", o_res_valid, 1);
      chk("res_data", o_res_data, er);
      chk("res_flags", o_flags, {ev, en, ez, ec});
      chk("hold_cmd_ready", o_cmd_ready, 0);
      if (i < hold) begin
        @(posedge clk); #1;
      end
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    acc_m = er;
    cnt_m = (cnt_m + 1) % 256;
    chk("drop_res_valid", o_res_valid, 0);
    chk("back_cmd_ready", o_cmd_ready, 1);
    chk("op_count", o_opc, cnt_m);
  endtask

  task automatic idle_gap(input int n);
    for (int i = 0; i < n; i++) begin
      res_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    res_ready = 1'b0;
    chk("idle_op_count", o_opc, cnt_m);
    chk("idle_res_valid", o_res_valid, 0);
  endtask

  task automatic reset_mid(input bit in_hold);
    int t;
    cmd_op    = OP_LOAD;
    cmd_data  = 8'hA5;
    cmd_valid = 1'b1;
    t = 0;
    while (!o_cmd_ready && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    if (in_hold) begin
      t = 0;
      while (!o_res_valid && t < 40) begin
        @(posedge clk); #1;
        t++;
      end
      chk("pre_rst_res_valid", o_res_valid, 1);
    end else begin
      chk("pre_rst_settle", o_cmd_ready, 0);
    end
    do_reset();
    @(posedge clk); #1;
    chk("post_rst_res_valid", o_res_valid, 0);
  endtask

  initial begin
    rst       = 1'b1;
    sel       = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = OP_ADD;
    cmd_data  = 8'h00;
    res_ready = 1'b0;
    corrupt   = 1'b0;
    acc_m     = 8'h00;
    cnt_m     = 0;
    repeat (2) @(posedge clk);
    #1;

    do_reset();
    run_cmd(OP_LOAD,  8'h05, 0, 0);
    run_cmd(OP_ADD,   8'h03, 0, 0);
    run_cmd(OP_SUB,   8'h08, 0, 0);
    run_cmd(OP_LOAD,  8'h7F, 0, 0);
    run_cmd(OP_ADD,   8'h01, 6, 0);
    run_cmd(OP_CLEAR, 8'h3C, 0, 0);
    run_cmd(OP_SUB,   8'h01, 0, 0);
    idle_gap(3);
    for (int k = 0; k < 40; k++) begin
      run_cmd(2'($urandom), 8'($urandom), $urandom_range(0, 3), 0);
      idle_gap($urandom_range(0, 2));
    end
    reset_mid(0);
    run_cmd(OP_LOAD, 8'h33, 0, 0);
    reset_mid(1);
    run_cmd(OP_ADD, 8'h11, 1, 0);

    sel = 1'b1;
    do_reset();
    run_cmd(OP_LOAD, 8'h10, 0, 1);
    run_cmd(OP_ADD,  8'h25, 0, 1);
    run_cmd(OP_SUB,  8'h40, 2, 1);
    for (int k = 0; k < 12; k++) begin
      run_cmd(2'($urandom), 8'($urandom), $urandom_range(0, 2), 1);
      idle_gap($urandom_range(0, 2));
    end
    reset_mid(0);
    run_cmd(OP_LOAD, 8'h80, 0, 1);
    reset_mid(1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/addsub_acc_ctrl.md
Name: addsub_acc_ctrl

Overview:
Sequencing stage wrapped around the 8-bit ripple-carry adder/subtractor. It accepts ADD/SUB/LOAD/CLEAR commands over a valid/ready handshake. It drives the adder with the accumulator and the command operand, waits a programmable settle time, then captures SUM/C_out into the accumulator. Each result is presented downstream with C/Z/N/V flags over a second valid/ready handshake.

Parameters:
WIDTH, 8, datapath width; must match the adder instance.
SETTLE_CYCLES, 1, cycles the adder inputs are held stable before SUM is sampled; legal range 1..15.

Ports:
clk  input  1  single clock, rising edge
rst  input  1  synchronous, active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  block can accept a command
cmd_op  input  2  00 ADD, 01 SUB, 10 LOAD, 11 CLEAR
cmd_data  input  WIDTH  operand
add_x  output  WIDTH  to adder X; always equals the accumulator
add_y  output  WIDTH  to adder Y; the registered operand
add_cin  output  1  to adder Cin; 1 for SUB, else 0
add_sum  input  WIDTH  from adder SUM
add_cout  input  1  from adder C_out
res_valid  output  1  result present
res_ready  input  1  downstream accepts the result
res_data  output  WIDTH  new accumulator value
res_c, res_z, res_n, res_v  output  1 each  carry, zero, negative, signed-overflow flags
op_count  output  8  completed results, wraps 0xFF -> 0x00

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE; acc, op_reg, res_data, all flags, op_count = 0; res_valid=0; cmd_ready=1 from the next cycle. Reset wins over any other event in every state, including mid-settle and mid-handshake. A pending result is discarded.
- States: IDLE, SETTLE, HOLD.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready: latch op_reg<=cmd_data, sub_reg<=(cmd_op==SUB), and the op code.
  - Load settle counter with SETTLE_CYCLES-1.
  - Go to SETTLE.
- SETTLE:
  - cmd_ready=0.
  - add_x/add_y/add_cin are registered and stable for the whole state.
  - Counter decrements each cycle.
  - When counter==0, the current edge captures the result and goes to HOLD.
- Capture rules:
  - ADD/SUB: acc<=add_sum; res_c=add_cout; res_v=(add_x[W-1]==yeff[W-1]) && (add_sum[W-1]!=add_x[W-1]), where yeff=add_y XOR {W{add_cin}}.
  - LOAD: acc<=op_reg; C=0, V=0.
  - CLEAR: acc<=0; C=0, V=0.
  - All ops: Z=(new acc==0), N=new acc[W-1]; res_data=new acc.
  - For SUB, C=1 means no borrow: adder output used unmodified.
- HOLD:
  - res_valid=1; res_data and flags stable while res_valid&&!res_ready.
  - On res_ready: op_count increments (wraps), then go to IDLE. res_valid drops the next cycle.
  - cmd_ready=0 throughout HOLD. There is no overlap; throughput is one command per SETTLE_CYCLES+2 cycles.
- Latency with SETTLE_CYCLES=1: command accepted at edge N, SETTLE during cycle N+1, res_valid=1 in cycle N+2. A result accepted at edge M allows a new command at edge M+1.
- The adder is purely combinational, so the block samples add_sum only at the last SETTLE edge. add_sum changing at other times is ignored.
- res_ready asserted while not in HOLD has no effect. cmd_valid held while cmd_ready=0 has no effect; the command must remain presented.

Decomposition:
- Shared package addsub_pkg:
  - op encodings OP_ADD/OP_SUB/OP_LOAD/OP_CLEAR
  - state encodings ST_IDLE/ST_SETTLE/ST_HOLD
  - flag bit positions
- One sub-module, addsub_flag_gen: combinational Z/N/V from sum, x, yeff, op. Instanced once.
- The adder is instanced beside this block at the top level, not inside it.

Test Plan:
- LOAD 0x05, then ADD 0x03 -> second result 0x08, C0 Z0 N0 V0; op_count=2.
- From acc 0x08, SUB 0x08 -> add_cin=1 during SETTLE; result 0x00, C1 Z1 N0 V0.
- LOAD 0x7F, ADD 0x01 -> 0x80, C0 Z0 N1 V1. Then SUB 0x01 from 0x00 after CLEAR -> 0xFF, C0 N1 V0.
- SETTLE_CYCLES=4: add_sum pulsed to a wrong value during the first 3 SETTLE cycles -> only the value at the 4th edge is captured. res_valid appears 5 cycles after accept.
- Hold res_ready=0 for 6 cycles after res_valid -> res_data and flags constant, cmd_ready=0. Release -> cmd_ready=1 the next cycle.
- Assert rst during SETTLE, and separately during HOLD -> next cycle: IDLE, acc=0, res_valid=0, op_count=0, cmd_ready=1.
